// File: rtl/resp_wptr_full.sv
// Response FIFO write side: read-pointer synchronizer, binary/gray write pointer,
// and registered full / almost-full / level / sticky overflow flags in rclk.
module resp_wptr_full #(
  parameter int unsigned ADDR_SIZE    = 3,
  parameter int unsigned AFULL_THRESH = 6,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 wpush,
  input  logic [ADDR_SIZE:0]   async_rptr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 woverflow
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_rptr;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] wlevel_next;

  // Far-side gray read pointer into rclk; nothing else touches async_rptr.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_rptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_rptr  = sync_q[SYNC_STAGES-1];
  assign wen        = wpush & ~wfull;
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign full_cmp   = {~sync_rptr[ADDR_SIZE:ADDR_SIZE-1], sync_rptr[ADDR_SIZE-2:0]};

  // Gray to binary: each bit is the XOR of itself and all higher gray bits.
  always_comb begin
    rbin_sync = '0;
    for (int unsigned i = 0; i < PW; i++) rbin_sync[i] = ^(sync_rptr >> i);
  end

  assign wlevel_next = wbin_next - rbin_sync;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      wbin         <= '0;
      waddr        <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      waddr        <= wbin_next[ADDR_SIZE-1:0];
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_cmp);
      walmost_full <= (wlevel_next >= PW'(AFULL_THRESH));
      wlevel       <= wlevel_next;
      woverflow    <= woverflow | (wpush & wfull);
    end
  end

endmodule

// File: tb/tb_resp_wptr_full.sv
// Bench for resp_wptr_full: directed scenarios plus random push/read traffic,
// checked against a push/read-count model of the FIFO write side.
module tb_resp_wptr_full;

  localparam int unsigned A  = 3;
  localparam int unsigned PW = A + 1;
  localparam int          N  = 1 << A;
  localparam int          M  = 1 << PW;
  localparam int          TH = 6;
  localparam int          SS = 2;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          wpush = 1'b0;
  logic [PW-1:0] async_rptr = '0;
  logic          wen;
  logic [A-1:0]  waddr;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;
  logic          woverflow;

  int tests = 0;
  int fails = 0;

  // Model: count of accepted pushes, far-side read count as seen after the sync lag.
  int            wcnt = 0;
  int            lvl = 0;
  bit            mfull = 0;
  bit            mafull = 0;
  bit            movf = 0;
  logic [PW-1:0] hist [SS];

  resp_wptr_full #(.ADDR_SIZE(A), .AFULL_THRESH(TH), .SYNC_STAGES(SS)) dut (
    .rclk(rclk), .rrst(rrst), .wpush(wpush), .async_rptr(async_rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  // Inverse gray by search over all codes.
  function automatic int g2b(input logic [PW-1:0] g);
    for (int n = 0; n < M; n++) if (gray(n) == g) return n;
    return 0;
  endfunction

  task automatic step(input bit r, input bit p, input logic [PW-1:0] a);
    logic [PW-1:0] s;
    int rc;
    @(negedge rclk);
    rrst = r; wpush = p; async_rptr = a;
    #1;
    if (!r) check("wen", 32'(wen), 32'(p && !mfull));
    @(posedge rclk);
    if (r) begin
      wcnt = 0; lvl = 0; mfull = 0; mafull = 0; movf = 0;
      for (int i = 0; i < SS; i++) hist[i] = '0;
    end else begin
      s = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = a;
      rc = g2b(s);
      if (p && mfull) movf = 1;
      else if (p) wcnt = (wcnt + 1) % M;
      lvl    = (wcnt - rc + M) % M;
      mfull  = (lvl == N);
      mafull = (lvl >= TH);
    end
    #1;
    check("waddr", 32'(waddr), 32'(wcnt % N));
    check("wptr", 32'(wptr), 32'(gray(wcnt)));
    check("wlevel", 32'(wlevel), 32'(lvl));
    check("wfull", 32'(wfull), 32'(mfull));
    check("walmost_full", 32'(walmost_full), 32'(mafull));
    check("woverflow", 32'(woverflow), 32'(movf));
  endtask

  initial begin
    logic [PW-1:0] fill_gray [N];
    logic [PW-1:0] prev;
    bit            seen_wrap;
    int            rfar;
    fill_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < SS; i++) hist[i] = '0;

    // Reset held with push and a nonzero far pointer
    step(1, 1, 4'b0101);
    step(1, 1, 4'b0101);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wptr", 32'(wptr), 0);

    // Fill to full
    for (int i = 0; i < N; i++) begin
      step(0, 1, '0);
      check("fill_waddr", 32'(waddr), 32'((i + 1) % N));
      check("fill_wptr", 32'(fill_gray[i]), 32'(wptr));
      if (i == TH - 1) check("fill_afull_at_thresh", 32'(walmost_full), 1);
    end
    check("fill_full", 32'(wfull), 1);
    check("fill_level", 32'(wlevel), 32'(N));

    // Overflow is dropped and sticky
    step(0, 1, '0);
    check("ovf_wptr_hold", 32'(wptr), 32'(4'b1100));
    for (int i = 0; i < 10; i++) step(0, 0, '0);
    check("ovf_sticky", 32'(woverflow), 1);

    // Far side reads one entry: visible on the third edge only
    step(0, 0, 4'b0001);
    check("rel_edge1_full", 32'(wfull), 1);
    step(0, 0, 4'b0001);
    check("rel_edge2_full", 32'(wfull), 1);
    step(0, 0, 4'b0001);
    check("rel_edge3_full", 32'(wfull), 0);
    check("rel_edge3_level", 32'(wlevel), 7);

    // Wrap: reader tracks the writer, so the FIFO never fills
    step(1, 0, '0);
    prev = '0;
    seen_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, gray(wcnt));
      check("wrap_hamming", 32'($countones(prev ^ wptr)), 1);
      check("wrap_level_le3", 32'(wlevel <= 3), 1);
      if (prev == 4'b1000 && wptr == 4'b0000) seen_wrap = 1;
      prev = wptr;
    end
    check("wrap_seen", 32'(seen_wrap), 1);

    // Reset in the middle of traffic
    for (int i = 0; i < 5; i++) step(0, 1, '0);
    step(1, 1, '0);
    step(0, 1, '0);
    check("midrst_waddr", 32'(waddr), 1);
    check("midrst_wptr", 32'(wptr), 32'(4'b0001));

    // Random traffic; far reader never overtakes the writer
    step(1, 0, '0);
    rfar = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && rfar != wcnt) rfar = (rfar + 1) % M;
      step(0, $urandom_range(0, 3) != 0, gray(rfar));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
